// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared constants for the load/store memory responders
package mem_if_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int WORD_BYTES = 4;
  localparam int ERR_BIT = 0;
  localparam int ERR_W = ERR_BIT + 1;
endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with synchronous write and asynchronous read
module mem_array #(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk) if (we) mem_q[idx] <= wdata;
  assign rdata = mem_q[idx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency handshaked load/store target with range and alignment checks
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int WS = $clog2(WORD_BYTES);
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             wr_q;
  logic [31:0]      addr_q, wdata_q, rdata_q, rdata_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             idle, cur_wr, bad, commit, we;
  logic [31:0]      cur_addr, cur_wdata, off, mem_rdata;
  assign idle = state_q == IDLE;
  // with LATENCY==1 the commit edge is the accept edge, so the live request is used
  assign cur_wr = idle ? req_write : wr_q;
  assign cur_addr = idle ? req_addr : addr_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;
  assign off = cur_addr - BASE_ADDR;
  assign bad = (cur_addr[WS-1:0] != '0) || (cur_addr < BASE_ADDR) || ((off >> WS) >= 32'(DEPTH_WORDS));
  assign commit = idle ? req_valid && LATENCY == 1 : state_q == WAIT && cnt_q == 4'd1;
  assign we = commit && cur_wr && !bad && !reset;
  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (off[AW+WS-1:WS]),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    if (idle && req_valid) begin
      state_d = LATENCY == 1 ? RESP : WAIT;
      cnt_d = 4'(LATENCY - 1);
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == RESP && resp_ready) begin
      state_d = IDLE;
      rdata_d = '0;
      err_d = '0;
    end
    if (commit) begin
      rdata_d = cur_wr || bad ? 32'd0 : mem_rdata;
      err_d = '0;
      err_d[ERR_BIT] = bad;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      if (idle && req_valid) begin
        wr_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end
  assign req_ready = idle;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_error = err_q[ERR_BIT];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (LATENCY 2, 4, 1) checked against an array-based memory model
module tb_mem_responder;
  logic clk = 1'b0;
  logic [2:0] reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [31:0] resp_rdata [3];
  logic [31:0] mem_m [3][64];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.DEPTH_WORDS(64), .LATENCY(g == 0 ? 2 : g == 1 ? 4 : 1), .BASE_ADDR(32'h0)) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_error (resp_error[g])
    );
  end

  function automatic int lat_of(input int k);
    return k == 0 ? 2 : k == 1 ? 4 : 1;
  endfunction

  // expected {error, rdata} for one transaction; applies committed stores to the model
  task automatic model_txn(input int k, input logic wr, input logic [31:0] a, input logic [31:0] wd, output logic [32:0] e);
    logic err;
    err = (a % 4 != 0) || (a >= 32'd256);
    e = {err, 32'd0};
    if (!err && wr) mem_m[k][a / 4] = wd;
    else if (!err) e[31:0] = mem_m[k][a / 4];
  endtask

  // obs = {latency, error, rdata, held_stable, ready/valid/error/rdata_nonzero after handshake}
  task automatic run_txn(input int k, input logic wr, input logic [31:0] a, input logic [31:0] wd, input int hold, output logic [45:0] obs);
    int lat;
    logic [31:0] rd;
    logic er, st;
    @(negedge clk);
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = wd;
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_write[k] = 1'b1; req_addr[k] = $urandom & 32'hFC; req_wdata[k] = $urandom;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (resp_valid[k] === 1'b1) begin lat = n; break; end
    end
    rd = resp_rdata[k]; er = resp_error[k]; st = 1'b1;
    for (int h = 0; h < hold; h++) begin
      req_valid[k] = 1'b1;
      @(negedge clk);
      if (resp_valid[k] !== 1'b1 || resp_rdata[k] !== rd || resp_error[k] !== er || req_ready[k] !== 1'b0) st = 1'b0;
    end
    req_valid[k] = 1'b0; resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    obs = {8'(lat), er, rd, st, req_ready[k], resp_valid[k], resp_error[k], |resp_rdata[k]};
  endtask

  task automatic test_reset();
    reset = 3'b111;
    repeat (2) @(negedge clk);
    reset = 3'b000;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({req_ready[k], resp_valid[k], resp_error[k], resp_rdata[k]} !== {3'b100, 32'd0}) begin
        failures++;
        $display("FAIL reset[%0d] {ready,valid,err,rdata}: got %h want %h", k, {req_ready[k], resp_valid[k], resp_error[k], resp_rdata[k]}, {3'b100, 32'd0});
      end
    end
  endtask

  task automatic test_store_load();
    logic [32:0] e;
    logic [45:0] obs;
    logic        tw [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      model_txn(0, tw[i], 32'h10, 32'hDEADBEEF, e);
      run_txn(0, tw[i], 32'h10, 32'hDEADBEEF, 0, obs);
      checks++;
      if (obs !== {8'd2, e, 5'b11000}) begin
        failures++;
        $display("FAIL store_load[%0d] obs: got %h want %h", i, obs, {8'd2, e, 5'b11000});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] e;
    logic [45:0] obs;
    logic [31:0] v;
    v = $urandom;
    model_txn(0, 1'b1, 32'h14, v, e);
    run_txn(0, 1'b1, 32'h14, v, 2, obs);
    checks++;
    if (obs !== {8'd2, e, 5'b11000}) begin
      failures++;
      $display("FAIL backpressure_store obs: got %h want %h", obs, {8'd2, e, 5'b11000});
    end
    model_txn(0, 1'b0, 32'h14, 32'h0, e);
    run_txn(0, 1'b0, 32'h14, 32'h0, 5, obs);
    checks++;
    if (obs !== {8'd2, e, 5'b11000}) begin
      failures++;
      $display("FAIL backpressure_load obs: got %h want %h", obs, {8'd2, e, 5'b11000});
    end
  endtask

  task automatic test_errors();
    logic [32:0] e;
    logic [45:0] obs;
    logic        tw [10] = '{1, 0, 1, 0, 1, 1, 0, 0, 0, 0};
    logic [31:0] ta [10] = '{32'h0, 32'h12, 32'h100, 32'h0, 32'h2, 32'hFC, 32'hFC, 32'h101, 32'hFFFF_FFFC, 32'h0};
    logic [31:0] td [10] = '{32'hC0FFEE00, 0, 32'h11111111, 0, 32'h22222222, 32'h33333333, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      model_txn(0, tw[i], ta[i], td[i], e);
      run_txn(0, tw[i], ta[i], td[i], i % 3, obs);
      checks++;
      if (obs !== {8'd2, e, 5'b11000}) begin
        failures++;
        $display("FAIL errors[%0d] addr %h obs: got %h want %h", i, ta[i], obs, {8'd2, e, 5'b11000});
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [32:0] e;
    logic [45:0] obs;
    logic        was_valid;
    model_txn(1, 1'b1, 32'h20, 32'hA5A5A5A5, e);
    run_txn(1, 1'b1, 32'h20, 32'hA5A5A5A5, 0, obs);
    checks++;
    if (obs !== {8'd4, e, 5'b11000}) begin
      failures++;
      $display("FAIL prewrite_lat4 obs: got %h want %h", obs, {8'd4, e, 5'b11000});
    end
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    checks++;
    if ({req_ready[1], resp_valid[1], resp_error[1], resp_rdata[1]} !== {3'b100, 32'd0}) begin
      failures++;
      $display("FAIL reset_in_wait outputs: got %h want %h", {req_ready[1], resp_valid[1], resp_error[1], resp_rdata[1]}, {3'b100, 32'd0});
    end
    model_txn(1, 1'b0, 32'h20, 32'h0, e);
    run_txn(1, 1'b0, 32'h20, 32'h0, 0, obs);
    checks++;
    if (obs !== {8'd4, e, 5'b11000}) begin
      failures++;
      $display("FAIL abandoned_store_read obs: got %h want %h", obs, {8'd4, e, 5'b11000});
    end
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h24; req_wdata[1] = 32'h0F0F1234;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    was_valid = resp_valid[1];
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    model_txn(1, 1'b1, 32'h24, 32'h0F0F1234, e);
    checks++;
    if ({was_valid, req_ready[1], resp_valid[1]} !== 3'b110) begin
      failures++;
      $display("FAIL reset_in_resp {valid_before,ready,valid}: got %b want 110", {was_valid, req_ready[1], resp_valid[1]});
    end
    model_txn(1, 1'b0, 32'h24, 32'h0, e);
    run_txn(1, 1'b0, 32'h24, 32'h0, 0, obs);
    checks++;
    if (obs !== {8'd4, e, 5'b11000}) begin
      failures++;
      $display("FAIL committed_store_read obs: got %h want %h", obs, {8'd4, e, 5'b11000});
    end
  endtask

  task automatic test_reset_with_req();
    logic [32:0] e;
    logic [45:0] obs;
    model_txn(0, 1'b1, 32'h30, 32'h600DCAFE, e);
    run_txn(0, 1'b1, 32'h30, 32'h600DCAFE, 0, obs);
    @(negedge clk);
    reset[0] = 1'b1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'hBAADBAAD;
    @(negedge clk);
    reset[0] = 1'b0; req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready[0], resp_valid[0]} !== 2'b10) begin
      failures++;
      $display("FAIL reset_with_req {ready,valid}: got %b want 10", {req_ready[0], resp_valid[0]});
    end
    model_txn(0, 1'b0, 32'h30, 32'h0, e);
    run_txn(0, 1'b0, 32'h30, 32'h0, 0, obs);
    checks++;
    if (obs !== {8'd2, e, 5'b11000}) begin
      failures++;
      $display("FAIL reset_with_req_read obs: got %h want %h", obs, {8'd2, e, 5'b11000});
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] q [$];
    logic [32:0] e;
    logic        tw [4] = '{1, 0, 1, 0};
    logic [31:0] ta [4] = '{32'h40, 32'h40, 32'h44, 32'h44};
    logic [31:0] td [4];
    int t, r;
    t = 0; r = 0;
    td[0] = $urandom; td[1] = 0; td[2] = $urandom; td[3] = 0;
    resp_ready[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid[2] === 1'b1) begin
        e = q.size() > 0 ? q.pop_front() : 33'h1_FFFF_FFFF;
        checks++;
        if ({resp_error[2], resp_rdata[2]} !== e) begin
          failures++;
          $display("FAIL back_to_back[%0d] {err,rdata}: got %h want %h", r, {resp_error[2], resp_rdata[2]}, e);
        end
        r++;
      end
      if (req_ready[2] === 1'b1 && t < 4) begin
        model_txn(2, tw[t], ta[t], td[t], e);
        q.push_back(e);
        req_valid[2] = 1'b1; req_write[2] = tw[t]; req_addr[2] = ta[t]; req_wdata[2] = td[t];
        t++;
      end
    end
    req_valid[2] = 1'b0;
    @(negedge clk);
    resp_ready[2] = 1'b0;
    checks++;
    if ({r[3:0], req_ready[2], resp_valid[2]} !== {4'd4, 2'b10}) begin
      failures++;
      $display("FAIL back_to_back_count {responses,ready,valid}: got %h want %h", {r[3:0], req_ready[2], resp_valid[2]}, {4'd4, 2'b10});
    end
  endtask

  task automatic test_random();
    logic [32:0] e;
    logic [45:0] obs;
    logic [31:0] a, d;
    logic        w;
    int          sel;
    for (int i = 0; i < 104; i++) begin
      d = $urandom;
      if (i < 64) begin
        w = 1'b1; a = 32'(i * 4);
      end else begin
        w = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        a = sel < 7 ? 32'($urandom_range(0, 63) * 4) : sel == 7 ? 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3)) : 32'($urandom_range(256, 4096)) | (sel == 9 ? 32'h8000_0000 : 32'h0);
      end
      model_txn(0, w, a, d, e);
      run_txn(0, w, a, d, i % 3, obs);
      checks++;
      if (obs !== {8'd2, e, 5'b11000}) begin
        failures++;
        $display("FAIL random[%0d] wr %b addr %h obs: got %h want %h", i, w, a, obs, {8'd2, e, 5'b11000});
      end
    end
  endtask

  initial begin
    reset = '0; req_valid = '0; req_write = '0; resp_ready = '0;
    for (int k = 0; k < 3; k++) begin req_addr[k] = '0; req_wdata[k] = '0; end
    test_reset();
    test_store_load();
    test_backpressure();
    test_errors();
    test_reset_mid_store();
    test_reset_with_req();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
